// File: rtl/dp_ram_arbiter_if.sv
// Requester-side bundle for dp_ram_arbiter: request handshake plus
// per-requester response strobe/data, packed one slice per requester.
interface dp_ram_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ*DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a
// dual-port RAM. Optional macro DP_RAM_ARB_STATS_EN adds conflict_cnt.
module dp_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int N_REQ      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dp_ram_arbiter_if.slave       bus,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef DP_RAM_ARB_STATS_EN
    ,
    output logic [15:0]           conflict_cnt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]      rr_q, rr_d;
    logic                  a_vld_q, b_vld_q;
    logic [IDX_W-1:0]      a_own_q, b_own_q;

    logic [IDX_W-1:0]      cand;
    int                    ci;
    logic                  a_hit, b_hit, blocked;
    logic [IDX_W-1:0]      a_idx, b_idx;
    logic                  a_we, b_we;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_din, b_din;
    logic [ADDR_WIDTH-1:0] c_addr;

    // Round-robin search for two winners; a same-address pair involving
    // a write is skipped so the two ports never race on one word.
    always_comb begin
        a_hit   = 1'b0;
        b_hit   = 1'b0;
        blocked = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        a_we    = 1'b0;
        b_we    = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        a_din   = '0;
        b_din   = '0;
        cand    = '0;
        ci      = 0;
        c_addr  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            ci     = (int'(rr_q) + k) % N_REQ;
            cand   = IDX_W'(ci);
            c_addr = bus.req_addr[ci*ADDR_WIDTH +: ADDR_WIDTH];
            if (!rst && bus.req_valid[cand]) begin
                if (!a_hit) begin
                    a_hit  = 1'b1;
                    a_idx  = cand;
                    a_we   = bus.req_we[cand];
                    a_addr = c_addr;
                    a_din  = bus.req_wdata[ci*DATA_WIDTH +: DATA_WIDTH];
                end else if (!b_hit) begin
                    if (c_addr == a_addr && (bus.req_we[cand] || a_we)) begin
                        blocked = 1'b1;
                    end else begin
                        b_hit  = 1'b1;
                        b_idx  = cand;
                        b_we   = bus.req_we[cand];
                        b_addr = c_addr;
                        b_din  = bus.req_wdata[ci*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Grant bits and RAM port drive; idle ports are fully zeroed.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_ready[i] = (a_hit && a_idx == IDX_W'(i)) ||
                               (b_hit && b_idx == IDX_W'(i));
        end
        ram_we_a   = a_hit & a_we;
        ram_addr_a = a_hit ? a_addr : '0;
        ram_din_a  = a_hit ? a_din  : '0;
        ram_we_b   = b_hit & b_we;
        ram_addr_b = b_hit ? b_addr : '0;
        ram_din_b  = b_hit ? b_din  : '0;
    end

    // Pointer moves just past the last winner; holds when nothing granted.
    always_comb begin
        rr_d = rr_q;
        if (b_hit) begin
            rr_d = IDX_W'((int'(b_idx) + 1) % N_REQ);
        end else if (a_hit) begin
            rr_d = IDX_W'((int'(a_idx) + 1) % N_REQ);
        end
    end

    // Single pipeline stage: pointer plus which requester owns each port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            a_own_q <= '0;
            b_own_q <= '0;
        end else begin
            rr_q    <= rr_d;
            a_vld_q <= a_hit;
            b_vld_q <= b_hit;
            a_own_q <= a_idx;
            b_own_q <= b_idx;
        end
    end

    // Route port dout back to its owner; reset masks a response in flight.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst && a_vld_q && a_own_q == IDX_W'(i)) begin
                bus.rsp_valid[i] = 1'b1;
                bus.rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_dout_a;
            end else if (!rst && b_vld_q && b_own_q == IDX_W'(i)) begin
                bus.rsp_valid[i] = 1'b1;
                bus.rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_dout_b;
            end
        end
    end

`ifdef DP_RAM_ARB_STATS_EN
    logic [15:0] cnt_q;

    // Saturating count of cycles where an address conflict held back a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (blocked && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = cnt_q;
`else
    logic unused_blocked;
    assign unused_blocked = blocked;
`endif

endmodule

// File: doc/dp_ram_arbiter.md
DP_RAM_ARBITER -- requirements
Module: dp_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the RAM word width in bits.
REQ-002 Parameter MEM_DEPTH, default 1024, SHALL set the number of RAM words.
REQ-003 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), SHALL set the address width.
REQ-004 Parameter N_REQ, default 4, legal range 2..8, SHALL set the requester count.
REQ-005 clk  in  1  SHALL be the single clock; all logic is on the rising edge.
REQ-006 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  SHALL be the per-requester request-valid bits.
REQ-008 req_ready  out  N_REQ  SHALL be the per-requester grant bits; a transfer occurs when valid and ready are both 1.
REQ-009 req_we  in  N_REQ  SHALL be the per-requester write enables (1 = write, 0 = read).
REQ-010 req_addr  in  N_REQ*ADDR_WIDTH  SHALL be the packed addresses; requester i uses slice i.
REQ-011 req_wdata  in  N_REQ*DATA_WIDTH  SHALL be the packed write data.
REQ-012 rsp_valid  out  N_REQ  SHALL be the per-requester response strobes.
REQ-013 rsp_rdata  out  N_REQ*DATA_WIDTH  SHALL be the packed response data.
REQ-014 ram_we_a, ram_addr_a, ram_din_a  out  1/ADDR_WIDTH/DATA_WIDTH  SHALL drive RAM port A.
REQ-015 ram_dout_a  in  DATA_WIDTH  SHALL be RAM port A read data, registered inside the RAM with 1-cycle latency.
REQ-016 ram_we_b, ram_addr_b, ram_din_b, ram_dout_b SHALL be the port B equivalents of REQ-014 and REQ-015.

Function
REQ-017 Each cycle, the arbiter SHALL grant at most two requesters, searched round-robin starting at index rr_ptr.
REQ-018 The first winner SHALL drive port A and the second winner SHALL drive port B, combinationally in the grant cycle.
REQ-019 An unused port SHALL drive we=0, with addr and din held at 0.
REQ-020 If the second candidate has the same address as the first winner and either request is a write, it SHALL NOT be granted that cycle; the search SHALL continue to the next candidate.
REQ-021 After any grant, rr_ptr SHALL become (index of the last winner + 1) mod N_REQ; with no grant, rr_ptr SHALL hold.
REQ-022 For every granted request, reads and writes alike, rsp_valid[i] SHALL pulse for exactly one cycle, one cycle after the grant.
REQ-023 rsp_rdata slice i SHALL carry the dout of the port that served requester i; for writes this is the pre-write (old) word.
REQ-024 rsp_rdata slices whose rsp_valid is 0 SHALL read 0.
REQ-025 A requester granted on consecutive cycles SHALL receive back-to-back responses in grant order.
REQ-026 req_ready SHALL depend only on req_valid, req_we, req_addr and rr_ptr; there is no combinational path from any RAM input.
REQ-027 With all N_REQ requesters continuously valid and conflict-free, each SHALL be granted at least once every ceil(N_REQ/2) cycles.
REQ-028 Port-owner and response-valid registers SHALL form a single pipeline stage; no other state besides rr_ptr.

Reset
REQ-029 While rst=1: rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, and both RAM ports SHALL have we=0.
REQ-030 A grant issued in the cycle before rst asserts SHALL have its response suppressed; any write already issued stays committed in RAM.
REQ-031 Arbitration SHALL resume on the first cycle after rst deasserts, starting at requester 0.

Configuration
REQ-032 With macro DP_RAM_ARB_STATS_EN defined, the block SHALL add output conflict_cnt (16 bits); it counts cycles in which REQ-020 blocked a grant, saturates at 0xFFFF, and clears on rst.
REQ-033 Without DP_RAM_ARB_STATS_EN, the conflict_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Case: N_REQ=4; requesters 0 and 2 read addr 5 and 9 in the same cycle (RAM[5]=0x11, RAM[9]=0x22). Expect: ready=0101 with port A=5, port B=9; next cycle rsp_valid=0101 with data 0x11 and 0x22.
REQ-035 Case: requesters 1 and 3 both write addr 7. Expect: only requester 1 granted that cycle; requester 3 granted the following cycle; conflict_cnt=1 when the macro is defined.
REQ-036 Case: all four requesters held valid for 4 cycles with distinct addresses. Expect grants 0+1, 2+3, 0+1, 2+3.
REQ-037 Case: requester 0 writes 0xAB to addr 3 (old value 0x5C), then reads addr 3. Expect the write response returns 0x5C and the read response returns 0xAB.
REQ-038 Case: rst asserted the cycle after the grant of a read to requester 2. Expect rsp_valid stays 0, all outputs are 0 during reset, and rr_ptr=0 afterwards.
REQ-039 Case: requesters 0 and 1 both read addr 4. Expect both granted in the same cycle (no conflict) and both return RAM[4].
